// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file completer.
// Optional pslverr reporting is enabled by defining APB_SLAVE_PSLVERR_EN.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int ID_IDX     = 0;

  // An address is in range when every bit at or above log2(depth) is clear.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int          width,
                                         input int          depth);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i < width) && ((longint'(1) << i) >= longint'(depth)) && addr[i])
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// DEPTH x WIDTH register storage: synchronous reset, one write port,
// combinational read port.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is reset on purpose (registers must read 0 after reset),
  // which maps it to flops rather than a RAM macro.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH x WIDTH register file, read-only ID at index 0
// and WAIT_CYCLES wait states. Define APB_SLAVE_PSLVERR_EN for error responses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 16,
  parameter int               WAIT_CYCLES = 2,
  parameter logic [WIDTH-1:0] ID_VALUE    = 'hA5B1
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             pselect,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  output logic             pslverr
);

  localparam int                    AW        = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [AW-1:0]         ID_SLOT   = AW'(ID_IDX);

  apb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [WIDTH-1:0]      prdata_q, prdata_d;
  logic [WIDTH-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic                  setup_phase, access_phase;
  logic [WIDTH-1:0]      dec_addr;
  logic                  dec_write;
  logic [AW-1:0]         dec_idx;
  logic                  dec_in_range;
  logic [WIDTH-1:0]      rd_value;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_we;
  logic                  load_resp;

  assign setup_phase  = pselect & ~penable;
  assign access_phase = pselect & penable;

  // Zero-wait transfers respond on the setup edge, before anything is latched,
  // so decode looks at the live bus in IDLE and at the latched copy in ACCESS.
  assign dec_addr     = (state_q == IDLE) ? paddr  : addr_q;
  assign dec_write    = (state_q == IDLE) ? pwrite : write_q;
  assign dec_idx      = dec_addr[AW-1:0];
  assign dec_in_range = addr_in_range(32'(dec_addr), WIDTH, DEPTH);

  always_comb begin
    rd_value = '0;
    if (dec_in_range) rd_value = (dec_idx == ID_SLOT) ? ID_VALUE : mem_rdata;
  end

`ifdef APB_SLAVE_PSLVERR_EN
  logic pslverr_q, pslverr_d;
  logic dec_err;

  assign dec_err = ~dec_in_range | (dec_write & (dec_idx == ID_SLOT));
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    mem_we    = 1'b0;
    load_resp = 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
    pslverr_d = pslverr_q;
`endif

    case (state_q)
      IDLE: begin
        if (setup_phase) begin
          addr_d    = paddr;
          wdata_d   = pwdata;
          write_d   = pwrite;
          cnt_d     = WAIT_INIT;
          pready_d  = (WAIT_CYCLES == 0);
          load_resp = (WAIT_CYCLES == 0);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!access_phase) begin
          pready_d = 1'b0;
          state_d  = IDLE;
`ifdef APB_SLAVE_PSLVERR_EN
          pslverr_d = 1'b0;
`endif
        end else if (!pready_q) begin
          cnt_d     = cnt_q - 1'b1;
          pready_d  = (cnt_q == WAIT_CNT_W'(1));
          load_resp = (cnt_q == WAIT_CNT_W'(1));
        end else begin
          mem_we   = write_q & dec_in_range & (dec_idx != ID_SLOT);
          pready_d = 1'b0;
          state_d  = IDLE;
`ifdef APB_SLAVE_PSLVERR_EN
          pslverr_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_resp) begin
      if (!dec_write) prdata_d = rd_value;
`ifdef APB_SLAVE_PSLVERR_EN
      pslverr_d = dec_err;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
    end
  end

`ifdef APB_SLAVE_PSLVERR_EN
  always_ff @(posedge pclk) begin
    if (!preset_n) pslverr_q <= 1'b0;
    else           pslverr_q <= pslverr_d;
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

  assign pready = pready_q;
  assign prdata = prdata_q;

  apb_slave_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (mem_we),
    .waddr    (dec_idx),
    .wdata    (wdata_q),
    .raddr    (dec_idx),
    .rdata    (mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: one zero-wait and one two-wait
// instance, directed scenarios followed by random transfers against a model.
module tb_apb_slave_regfile;

  localparam logic [15:0] ID = 16'hA5B1;
  localparam int          LAT [2] = '{1, 3};  // access cycle in which pready rises

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic        pready_w  [2];
  logic [15:0] prdata_w  [2];
  logic        pslverr_w [2];

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .pselect(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]));

  apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut1 (
    .pclk(pclk), .preset_n(preset_n), .pselect(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]));

  logic [15:0] model   [2][16];
  logic [15:0] last_rd [2];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) model[d][i] = '0;
      last_rd[d] = '0;
    end
  endtask

  // Full transfer on instance d, starting at a negedge with the bus idle.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input string tag);
    int          n;
    logic        in_rng;
    logic        exp_err;
    logic [15:0] exp_rd;
    in_rng  = (addr < 16);
    exp_rd  = !in_rng ? 16'h0 : (addr == 0) ? ID : model[d][addr[3:0]];
    exp_err = 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
    exp_err = !in_rng || (wr && addr == 0);
`endif
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = 16'($urandom);   // must be ignored once latched
    pwdata  = 16'($urandom);
    n = 1;
    while (!pready_w[d] && n < 40) begin
      @(negedge pclk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT[d]));
    if (wr) begin
      check({tag, " prdata hold"}, 32'(prdata_w[d]), 32'(last_rd[d]));
      if (in_rng && addr != 0) model[d][addr[3:0]] = data;
    end else begin
      check({tag, " prdata"}, 32'(prdata_w[d]), 32'(exp_rd));
      last_rd[d] = exp_rd;
    end
    check({tag, " pslverr"}, 32'(pslverr_w[d]), 32'(exp_err));
    @(negedge pclk);
    psel    = '0;
    penable = 1'b0;
    check({tag, " pready drop"}, 32'(pready_w[d]), 32'd0);
  endtask

  initial begin
    int          d;
    int          r;
    logic        wr;
    logic [15:0] addr;

    preset_n = 1'b0;
    psel     = '0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    clear_model();
    repeat (3) @(negedge pclk);
    for (int k = 0; k < 2; k++) begin
      check("reset pready",  32'(pready_w[k]),  32'd0);
      check("reset prdata",  32'(prdata_w[k]),  32'd0);
      check("reset pslverr", 32'(pslverr_w[k]), 32'd0);
    end
    preset_n = 1'b1;
    @(negedge pclk);

    // Two-wait write/read
    xfer(1, 1'b1, 16'd3, 16'h1234, "t1 wr3");
    xfer(1, 1'b0, 16'd3, 16'h0,    "t1 rd3");

    // Zero-wait back-to-back
    xfer(0, 1'b1, 16'd1, 16'h1111, "t2 wr1");
    xfer(0, 1'b1, 16'd2, 16'h2222, "t2 wr2");
    xfer(0, 1'b0, 16'd1, 16'h0,    "t2 rd1");
    xfer(0, 1'b0, 16'd2, 16'h0,    "t2 rd2");

    // ID register is read-only
    xfer(1, 1'b0, 16'd0, 16'h0,    "t3 rd id");
    xfer(1, 1'b1, 16'd0, 16'hFFFF, "t3 wr id");
    xfer(1, 1'b0, 16'd0, 16'h0,    "t3 rd id again");
    xfer(0, 1'b1, 16'd0, 16'hFFFF, "t3 wr id z");

    // Out-of-range accesses leave the file alone
    xfer(1, 1'b0, 16'h0100, 16'h0,    "t4 rd oor");
    xfer(1, 1'b1, 16'h0103, 16'hDEAD, "t4 wr oor");
    xfer(1, 1'b0, 16'd3,    16'h0,    "t4 rd3");

    // Abort a write during its wait state
    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 16'd5;
    pwdata  = 16'h5555;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("t5 no ready in wait", 32'(pready_w[1]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    check("t5 no ready after abort", 32'(pready_w[1]), 32'd0);
    // Access strobe without a setup phase is ignored
    psel    = 2'b10;
    penable = 1'b1;
    repeat (4) @(negedge pclk);
    check("t5 no setup ignored", 32'(pready_w[1]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    xfer(1, 1'b0, 16'd5, 16'h0, "t5 rd5");
    xfer(1, 1'b0, 16'd3, 16'h0, "t5 rd3");

    // Reset in the middle of a write
    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 16'd7;
    pwdata  = 16'hBEEF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    @(negedge pclk);
    check("t6 pready",  32'(pready_w[1]),  32'd0);
    check("t6 prdata",  32'(prdata_w[1]),  32'd0);
    check("t6 pslverr", 32'(pslverr_w[1]), 32'd0);
    preset_n = 1'b1;
    psel     = '0;
    penable  = 1'b0;
    clear_model();
    @(negedge pclk);
    xfer(1, 1'b0, 16'd7, 16'h0, "t6 rd7");
    xfer(1, 1'b0, 16'd3, 16'h0, "t6 rd3");
    xfer(0, 1'b0, 16'd1, 16'h0, "t6 rd1 z");

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      addr = {12'($urandom_range(1, 4095)), 4'($urandom)};
      else if (r == 1) addr = 16'd0;
      else             addr = 16'($urandom_range(1, 15));
      xfer(d, wr, addr, 16'($urandom), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
